barrel_unshifter_seq: RTL
=========================

Name: barrel_unshifter_seq

Overview:
- Multi-cycle right shifter/rotator, the reverse-direction companion of the 8-bit combinational left barrel shifter.
- Undoes a left shift or rotate by `ctrl` positions. Applies one log2 stage per clock (4, 2, 1 for WIDTH=8), so the datapath is a single muxed shift stage instead of a full combinational barrel.
- Sits behind the barrel shifter in the datapath. Uses a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two ≥ 2.
- SHW, 3, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request carries valid in/ctrl/mode.
- in_ready  output  1  block can accept a request.
- in  input  WIDTH  data to shift right.
- ctrl  input  SHW  shift amount, 0..WIDTH-1.
- mode  input  2  00 logical right, 01 rotate right, 10 arithmetic right, 11 reserved (treated as logical).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  shifted result.

Behaviour:
- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, out=0, stage counter=0, latched ctrl/mode=0. Reset mid-operation discards the operation; no output is produced for it.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, latch in into the data register and latch ctrl and mode. Set stage=SHW-1. Go to SHIFT.
  - SHIFT: in_ready=0. Each edge: if latched ctrl[stage]=1, shift the data register right by 2^stage using the latched mode; else hold it. If stage==0, go to DONE and set out_valid=1; else decrement stage.
  - DONE: out_valid=1, in_ready=0. out equals the data register and stays stable while out_ready=0. On out_valid && out_ready, go to IDLE and set out_valid=0.
- Stages run MSB first (4, 2, 1). Latency is fixed at SHW edges from the accept edge to out_valid rising, independent of the ctrl value. ctrl=0 still takes SHW cycles.
- Throughput: in_ready is high only in IDLE. Minimum initiation interval is SHW+2 cycles (accept, SHW shift edges, handshake edge). No overlap between requests.
- Fill rules:
  - Logical: zero-fill.
  - Arithmetic: fill with the latched in[WIDTH-1], captured at accept.
  - Rotate: bits shifted out of the LSB re-enter at the MSB.
- in, ctrl and mode are sampled only at the accept edge. Later changes have no effect on the in-flight operation.
- in_valid while busy is ignored; the requester must hold the request until in_ready.
- out_ready while out_valid=0 has no effect.
- out holds its last result after the handshake until the next operation overwrites it in SHIFT.
- All shifts are exact WIDTH-bit arithmetic; no width growth, no overflow flag.

Decomposition:
- Shared package barrel_pkg:
  - mode encodings MODE_LSR=2'b00, MODE_ROR=2'b01, MODE_ASR=2'b10.
  - state typedef {IDLE, SHIFT, DONE}.
- One natural sub-module: shift_stage_r. Combinational; right-shifts a WIDTH word by 0 or 2^k per a select, mode and fill bit. Instantiated once, with its amount driven by the stage counter.

Test Plan:
- Reset/idle: assert rst_n=0 mid-SHIFT (after accepting in=255, ctrl=4) -> immediately out_valid=0, out=0, in_ready=1. After release, no result appears.
- Logical: in=255, ctrl=4, mode=00 -> out_valid rises exactly 3 edges after accept with out=15. in=255, ctrl=7 -> out=1.
- Rotate: in=150 (1001_0110), ctrl=2, mode=01 -> out=165 (1010_0101). in=255, ctrl=4 -> out=255.
- Arithmetic: in=150, ctrl=2, mode=10 -> out=229 (1110_0101). Same input with mode=00 -> out=37.
- Zero shift and reserved mode: in=8'hA5, ctrl=0, mode=11 -> out=8'hA5 after 3 edges; mode=11 behaves as logical.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles while toggling in and in_valid -> out, out_valid and in_ready stay constant (in_ready=0). Release out_ready -> one handshake, then in_ready=1 the next cycle. Back-to-back requests are accepted every 5 cycles.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared encodings for the barrel shifter family: shift modes and sequencer states.
package barrel_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned SHW_DEF   = 3;
  localparam int unsigned MODE_W    = 2;

  localparam logic [MODE_W-1:0] MODE_LSR = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ROR = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ASR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage_r.sv
// One right-shift stage: shifts by 0 or 2^stage_i with logical, rotate or arithmetic fill.
module shift_stage_r
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SHW   = SHW_DEF
) (
  input  logic [WIDTH-1:0]  data_i,
  input  logic              sel_i,
  input  logic [SHW-1:0]    stage_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              fill_i,
  output logic [WIDTH-1:0]  data_c
);

  logic [WIDTH-1:0] upper;
  logic [SHW-1:0]   amt;

  // Upper half of a double-width word supplies the bits that enter at the MSB.
  always_comb begin
    amt = SHW'(1) << stage_i;
    case (mode_i)
      MODE_ROR: upper = data_i;
      MODE_ASR: upper = {WIDTH{fill_i}};
      default:  upper = '0;
    endcase
    data_c = sel_i ? WIDTH'({upper, data_i} >> amt) : data_i;
  end

endmodule

// File: rtl/barrel_unshifter_seq.sv
// Sequential right shifter/rotator: one log2 stage per clock, MSB stage first, valid/ready on both sides.
module barrel_unshifter_seq
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SHW   = SHW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in,
  input  logic [SHW-1:0]    ctrl,
  input  logic [MODE_W-1:0] mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out
);

  state_t              state_q, state_d;
  logic [SHW-1:0]      stage_q, stage_d;
  logic [SHW-1:0]      ctrl_q, ctrl_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                fill_q, fill_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                stage_sel;
  logic [WIDTH-1:0]    stage_res_c;

  assign stage_sel = |(ctrl_q & (SHW'(1) << stage_q));

  shift_stage_r #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_stage (
    .data_i  (data_q),
    .sel_i   (stage_sel),
    .stage_i (stage_q),
    .mode_i  (mode_q),
    .fill_i  (fill_q),
    .data_c  (stage_res_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      ctrl_q      <= '0;
      mode_q      <= '0;
      fill_q      <= 1'b0;
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      ctrl_q      <= ctrl_d;
      mode_q      <= mode_d;
      fill_q      <= fill_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath control; handshake flags follow the next state.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    ctrl_d  = ctrl_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d  = in;
          ctrl_d  = ctrl;
          mode_d  = mode;
          fill_d  = in[WIDTH-1];
          stage_d = SHW'(SHW - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        data_d = stage_res_c;
        if (stage_q == '0) begin
          state_d = DONE;
        end else begin
          stage_d = stage_q - SHW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = data_q;

endmodule
